// File: rtl/pwm_pkg.sv
// pwm_pkg: shared constants for the PWM generator/capture blocks.
package pwm_pkg;

  localparam int PWM_W_DEF       = 16;
  localparam int PWM_TIMEOUT_DEF = 4096;
  localparam int AVG_FRAMES      = 4;

  typedef enum logic [1:0] {
    S_WAIT = 2'd0,
    S_HIGH = 2'd1,
    S_LOW  = 2'd2
  } state_e;

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser for a single asynchronous input.
module sync_2ff (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_q;

  // Two back-to-back flops; r_meta may go metastable, r_q is safe to use.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= 1'b0;
      r_q    <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_q    <= r_meta;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/pwm_capture.sv
// pwm_capture: measures high time and period of an asynchronous PWM input,
// one result per frame, with a timeout result for a constant-level line.
// Optional averaging over AVG_FRAMES frames: define PWM_CAPTURE_AVG_EN.
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int W       = PWM_W_DEF,
  parameter int TIMEOUT = PWM_TIMEOUT_DEF
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_pwm_in,
  output logic [W-1:0] o_high_time,
  output logic [W-1:0] o_period,
  output logic         o_valid,
  output logic         o_timeout,
  output logic         o_level
);

  localparam logic [W-1:0] CNT_MAX = '1;
  localparam logic [W-1:0] TO_CNT  = W'(TIMEOUT);

  logic         w_s;
  logic         r_s_d;
  logic         w_rise;
  logic         w_fall;
  logic         w_tc;
  logic [W-1:0] r_cnt;
  logic [W-1:0] r_hi_lat;
  state_e       r_state;
  state_e       w_state_nxt;
  logic         w_lat_hi;
  logic         w_meas;
  logic         w_to;
  logic         w_emit;
  logic [W-1:0] w_ht;
  logic [W-1:0] w_per;

  logic [W-1:0] r_high_time;
  logic [W-1:0] r_period;
  logic         r_valid;
  logic         r_timeout;
  logic         r_level;

  sync_2ff u_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_d     (i_pwm_in),
    .o_q     (w_s)
  );

  // Delayed copy of the synchronised level for edge detection. Both edges
  // see the same synchroniser latency, so the measurements stay exact.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_s_d <= 1'b0;
    else          r_s_d <= w_s;
  end

  assign w_rise = w_s & ~r_s_d;
  assign w_fall = ~w_s & r_s_d;
  assign w_tc   = (r_cnt == TO_CNT);

  // Cycle counter: restarts at 1 after each rise, otherwise saturates.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)               r_cnt <= '0;
    else if (w_rise)            r_cnt <= W'(1);
    else if (r_cnt != CNT_MAX)  r_cnt <= r_cnt + W'(1);
  end

  // FSM state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_WAIT;
    else          r_state <= w_state_nxt;
  end

  // FSM next state and event decode. The expected edge beats the terminal
  // count; the counter passes TIMEOUT only once per rise, so a timeout is
  // never repeated until an edge restarts it.
  always_comb begin
    w_state_nxt = r_state;
    w_lat_hi    = 1'b0;
    w_meas      = 1'b0;
    w_to        = 1'b0;
    case (r_state)
      S_WAIT: begin
        if (w_rise)    w_state_nxt = S_HIGH;
        else if (w_tc) w_to        = 1'b1;
      end
      S_HIGH: begin
        if (w_fall) begin
          w_lat_hi    = 1'b1;
          w_state_nxt = S_LOW;
        end else if (w_tc) begin
          w_to        = 1'b1;
          w_state_nxt = S_WAIT;
        end
      end
      S_LOW: begin
        if (w_rise) begin
          w_meas      = 1'b1;
          w_state_nxt = S_HIGH;
        end else if (w_tc) begin
          w_to        = 1'b1;
          w_state_nxt = S_WAIT;
        end
      end
      default: w_state_nxt = S_WAIT;
    endcase
  end

  // High-time latch, captured on the falling edge of the frame.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)      r_hi_lat <= '0;
    else if (w_lat_hi) r_hi_lat <= r_cnt;
  end

`ifdef PWM_CAPTURE_AVG_EN
  logic [W+1:0] r_sum_h;
  logic [W+1:0] r_sum_p;
  logic [1:0]   r_frm;
  logic [W+1:0] w_sum_h;
  logic [W+1:0] w_sum_p;

  assign w_sum_h = r_sum_h + (W+2)'(r_hi_lat);
  assign w_sum_p = r_sum_p + (W+2)'(r_cnt);
  assign w_emit  = w_meas & (r_frm == 2'(AVG_FRAMES - 1));
  assign w_ht    = w_sum_h[W+1:2];
  assign w_per   = w_sum_p[W+1:2];

  // Accumulators: cleared on timeout and after each averaged result.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sum_h <= '0;
      r_sum_p <= '0;
      r_frm   <= '0;
    end else if (w_to || w_emit) begin
      r_sum_h <= '0;
      r_sum_p <= '0;
      r_frm   <= '0;
    end else if (w_meas) begin
      r_sum_h <= w_sum_h;
      r_sum_p <= w_sum_p;
      r_frm   <= r_frm + 2'd1;
    end
  end
`else
  assign w_emit = w_meas;
  assign w_ht   = r_hi_lat;
  assign w_per  = r_cnt;
`endif

  // Result registers: one-cycle valid strobe, values held in between.
  // level only follows the line on a timeout result.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_high_time <= '0;
      r_period    <= '0;
      r_valid     <= 1'b0;
      r_timeout   <= 1'b0;
      r_level     <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (w_to) begin
        r_valid     <= 1'b1;
        r_timeout   <= 1'b1;
        r_level     <= w_s;
        r_high_time <= w_s ? CNT_MAX : '0;
        r_period    <= '0;
      end else if (w_emit) begin
        r_valid     <= 1'b1;
        r_timeout   <= 1'b0;
        r_high_time <= w_ht;
        r_period    <= w_per;
      end
    end
  end

  assign o_high_time = r_high_time;
  assign o_period    = r_period;
  assign o_valid     = r_valid;
  assign o_timeout   = r_timeout;
  assign o_level     = r_level;

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: directed bench for pwm_capture (W=16, TIMEOUT=4096).
module tb_pwm_capture;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pwm_in = 1'b0;
  logic [15:0] high_time;
  logic [15:0] period;
  logic        valid;
  logic        timeout;
  logic        level;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int c_rise = 0;

  typedef struct {
    logic [15:0] ht;
    logic [15:0] per;
    logic        to;
    logic        lvl;
    int          cyc;
  } rec_t;
  rec_t q[$];

  pwm_capture #(.W(16), .TIMEOUT(4096)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_pwm_in    (pwm_in),
    .o_high_time (high_time),
    .o_period    (period),
    .o_valid     (valid),
    .o_timeout   (timeout),
    .o_level     (level)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Record every result strobe, sampled away from the active edge.
  always @(negedge clk) begin
    if (valid) q.push_back('{high_time, period, timeout, level, cyc});
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Check one recorded result; an absent record counts as a failure.
  task automatic chk_rec(input string tag, input int idx, input logic [15:0] ht,
                         input logic [15:0] per, input logic to);
    if (idx < q.size()) begin
      chk({tag, ".ht"},  32'(q[idx].ht),  32'(ht));
      chk({tag, ".per"}, 32'(q[idx].per), 32'(per));
      chk({tag, ".to"},  32'(q[idx].to),  32'(to));
    end else begin
      chk({tag, ".present"}, 32'(q.size()), 32'(idx + 1));
    end
  endtask

  // Drive one frame starting on a falling clock edge.
  task automatic frame(input int h, input int p);
    pwm_in = 1'b1;
    repeat (h) @(negedge clk);
    pwm_in = 1'b0;
    repeat (p - h) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst.ht",    32'(high_time), 32'd0);
    chk("rst.per",   32'(period),    32'd0);
    chk("rst.valid", 32'(valid),     32'd0);
    chk("rst.to",    32'(timeout),   32'd0);
    chk("rst.lvl",   32'(level),     32'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

`ifdef PWM_CAPTURE_AVG_EN
    q.delete();
    frame(30, 64); frame(32, 64); frame(34, 64); frame(36, 64);
    pwm_in = 1'b1;
    repeat (10) @(negedge clk);
    chk("avg.count", 32'(q.size()), 32'd1);
    chk_rec("avg", 0, 16'd33, 16'd64, 1'b0);
`else
    // Steady 50 % frames: the fifth frame is closed only by the next rise.
    for (int i = 0; i < 5; i++) frame(32, 64);
    chk("steady.count", 32'(q.size()), 32'd4);
    for (int i = 0; i < 4; i++) chk_rec($sformatf("steady%0d", i), i, 16'd32, 16'd64, 1'b0);

    // Duty sweep, then one more frame that goes quiet low.
    q.delete();
    frame(3, 64); frame(40, 64); frame(63, 64);
    pwm_in = 1'b1;
    c_rise = cyc;
    repeat (32) @(negedge clk);
    pwm_in = 1'b0;
    repeat (5000) @(negedge clk);
    chk("sweep.count", 32'(q.size()), 32'd5);
    chk_rec("sweep_f5", 0, 16'd32, 16'd64, 1'b0);
    chk_rec("sweep3",   1, 16'd3,  16'd64, 1'b0);
    chk_rec("sweep40",  2, 16'd40, 16'd64, 1'b0);
    chk_rec("sweep63",  3, 16'd63, 16'd64, 1'b0);
    chk_rec("tolow",    4, 16'd0,  16'd0,  1'b1);
    if (q.size() == 5) begin
      chk("tolow.lvl", 32'(q[4].lvl), 32'd0);
      // 2 sync + 1 edge-detect cycles, then TIMEOUT counts, then the output flop.
      chk("tolow.delay", 32'(q[4].cyc - c_rise), 32'd4099);
    end

    // Line stuck high.
    q.delete();
    pwm_in = 1'b1;
    repeat (5000) @(negedge clk);
    chk("tohigh.count", 32'(q.size()), 32'd1);
    chk_rec("tohigh", 0, 16'hFFFF, 16'd0, 1'b1);
    if (q.size() >= 1) chk("tohigh.lvl", 32'(q[0].lvl), 32'd1);
    pwm_in = 1'b0;
    repeat (20) @(negedge clk);
    chk("tohigh.norepeat", 32'(q.size()), 32'd1);

    // Asynchronous reset in the low phase of a frame.
    q.delete();
    frame(32, 64); frame(32, 64);
    pwm_in = 1'b1;
    repeat (32) @(negedge clk);
    pwm_in = 1'b0;
    repeat (10) @(negedge clk);
    chk("prerst.ht", 32'(high_time), 32'd32);
    #3 rst_n = 1'b0;
    #1;
    chk("midrst.ht",  32'(high_time), 32'd0);
    chk("midrst.per", 32'(period),    32'd0);
    chk("midrst.lvl", 32'(level),     32'd0);
    chk("midrst.to",  32'(timeout),   32'd0);
    #2 rst_n = 1'b1;
    q.delete();
    @(negedge clk);
    repeat (20) @(negedge clk);
    frame(10, 64);
    chk("postrst.none", 32'(q.size()), 32'd0);
    frame(10, 64);
    chk("postrst.count", 32'(q.size()), 32'd1);
    chk_rec("postrst", 0, 16'd10, 16'd64, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
